set_assoc_cache: RTL

- Parametrised N-way set-associative, write-through, one-word-per-line data cache between CPU load/store unit and data memory.
- Generalises the 4-entry fully-associative word cache with:
  - configurable sets, ways and width;
  - a ready/ack memory handshake;
  - byte-enable stores;
  - synchronous reset and flush.
- Per-set true-LRU replacement using age counters.

---
 rtl/cache_pkg.sv | 48 ++++
 rtl/cache_lru.sv | 54 +++++
 rtl/set_assoc_cache.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared types, address-split helpers and byte merge for the
//               set-associative data cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  // Widest word the merge helper handles; callers cast in and out of it.
  localparam int c_max_data_w = 512;
  localparam int c_max_be_w   = c_max_data_w / 8;

  function automatic int offset_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w, input int sets);
    return addr_w - offset_w(data_w) - index_w(sets);
  endfunction

  function automatic logic [c_max_data_w-1:0] byte_merge(
    input logic [c_max_data_w-1:0] old_word,
    input logic [c_max_data_w-1:0] new_word,
    input logic [c_max_be_w-1:0]   be
  );
    logic [c_max_data_w-1:0] merged;
    merged = old_word;
    for (int b = 0; b < c_max_be_w; b++) begin
      if (be[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_lru.sv
// ============================================================================
// Module      : cache_lru
// Description : Per-set true-LRU age tracker and victim selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_lru #(
  parameter int WAYS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     access_i,
  input  logic [$clog2(WAYS)-1:0]  way_i,
  input  logic [WAYS-1:0]          valid_i,
  output logic [$clog2(WAYS)-1:0]  victim_o
);

  localparam int c_way_w = $clog2(WAYS);

  logic [c_way_w-1:0] r_age [WAYS];
  logic               w_found;

  // Age WAYS-1 is most recent, 0 is least; ages stay a permutation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < WAYS; w++) r_age[w] <= c_way_w'(w);
    end else if (access_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (c_way_w'(w) == way_i)        r_age[w] <= c_way_w'(WAYS - 1);
        else if (r_age[w] > r_age[way_i]) r_age[w] <= r_age[w] - 1'b1;
      end
    end
  end

  always_comb begin
    victim_o = '0;
    w_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !valid_i[w]) begin
        victim_o = c_way_w'(w);
        w_found  = 1'b1;
      end
    end
    if (!w_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[w] == '0) victim_o = c_way_w'(w);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/set_assoc_cache.sv
// ============================================================================
// Module      : set_assoc_cache
// Description : N-way set-associative write-through word cache with LRU.
//               Define CACHE_STATS_EN to add saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 4,
  parameter int SETS   = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_wdata_i,
  input  logic [DATA_W/8-1:0] cpu_be_i,
  input  logic                flush_i,
  output logic                ready_o,
  output logic                hit_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ack_i,
`ifdef CACHE_STATS_EN
  output logic [31:0]         stat_hits_o,
  output logic [31:0]         stat_misses_o,
`endif
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int c_offset_w = offset_w(DATA_W);
  localparam int c_index_w  = index_w(SETS);
  localparam int c_idx_w    = (c_index_w > 0) ? c_index_w : 1;
  localparam int c_tag_w    = tag_w(ADDR_W, DATA_W, SETS);
  localparam int c_way_w    = $clog2(WAYS);
  localparam logic [ADDR_W-1:0] c_off_mask =
    ~((ADDR_W'(1) << c_offset_w) - ADDR_W'(1));

  state_t r_state, w_state_nxt;

  logic [WAYS-1:0]    r_valid [SETS];
  logic [c_tag_w-1:0] r_tag   [SETS][WAYS];
  logic [DATA_W-1:0]  r_data  [SETS][WAYS];
  logic               r_wr_hit;

  logic [c_idx_w-1:0] w_acc_idx;
  logic [c_tag_w-1:0] w_acc_tag;
  logic               w_hit;
  logic [c_way_w-1:0] w_hit_way;
  logic [c_way_w-1:0] w_victim [SETS];
  logic [c_way_w-1:0] w_victim_sel;
  logic               w_lru_access;
  logic [c_way_w-1:0] w_lru_way;
  logic               w_mem_start;
  logic               w_store_wr;
  logic [c_way_w-1:0] w_store_way;
  logic               w_fill;
  logic [DATA_W-1:0]  w_store_data;

  // Lookup uses the live CPU address in IDLE, the latched one otherwise.
  assign w_acc_tag = (r_state == IDLE) ? cpu_addr_i[ADDR_W-1 -: c_tag_w]
                                       : mem_addr_o[ADDR_W-1 -: c_tag_w];

  generate
    if (SETS > 1) begin : g_index
      assign w_acc_idx = (r_state == IDLE) ? cpu_addr_i[c_offset_w +: c_index_w]
                                           : mem_addr_o[c_offset_w +: c_index_w];
    end else begin : g_no_index
      assign w_acc_idx = '0;
    end
  endgenerate

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_acc_idx][w] && (r_tag[w_acc_idx][w] == w_acc_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = c_way_w'(w);
      end
    end
  end

  generate
    for (genvar s = 0; s < SETS; s++) begin : g_set
      cache_lru #(.WAYS(WAYS)) u_lru (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .access_i (w_lru_access && (w_acc_idx == c_idx_w'(s))),
        .way_i    (w_lru_way),
        .valid_i  (r_valid[s]),
        .victim_o (w_victim[s])
      );
    end
  endgenerate

  assign w_victim_sel = w_victim[w_acc_idx];
  assign w_store_data = DATA_W'(byte_merge(c_max_data_w'(r_data[w_acc_idx][w_store_way]),
                                           c_max_data_w'(cpu_wdata_i),
                                           c_max_be_w'(cpu_be_i)));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    ready_o      = 1'b0;
    hit_o        = 1'b0;
    rdata_o      = '0;
    w_lru_access = 1'b0;
    w_lru_way    = w_hit_way;
    w_mem_start  = 1'b0;
    w_store_wr   = 1'b0;
    w_store_way  = w_hit_way;
    w_fill       = 1'b0;
    case (r_state)
      IDLE: begin
        // Flush wins; a concurrent request simply waits a cycle.
        if (!flush_i && cpu_req_i) begin
          if (!cpu_we_i) begin
            if (w_hit) begin
              ready_o      = 1'b1;
              hit_o        = 1'b1;
              rdata_o      = r_data[w_acc_idx][w_hit_way];
              w_lru_access = 1'b1;
            end else begin
              w_mem_start = 1'b1;
              w_state_nxt = RD_MISS;
            end
          end else begin
            w_mem_start = 1'b1;
            w_state_nxt = WR_THRU;
            if (w_hit) begin
              w_store_wr   = 1'b1;
              w_lru_access = 1'b1;
            end else if (&cpu_be_i) begin
              w_store_wr   = 1'b1;
              w_store_way  = w_victim_sel;
              w_lru_access = 1'b1;
              w_lru_way    = w_victim_sel;
            end
          end
        end
      end
      RD_MISS: begin
        if (mem_ack_i) begin
          ready_o      = 1'b1;
          rdata_o      = mem_rdata_i;
          w_fill       = 1'b1;
          w_lru_access = 1'b1;
          w_lru_way    = w_victim_sel;
          w_state_nxt  = IDLE;
        end
      end
      WR_THRU: begin
        if (mem_ack_i) begin
          ready_o     = 1'b1;
          hit_o       = r_wr_hit;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
    end else if ((r_state == IDLE) && flush_i) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
    end else if (w_store_wr) begin
      r_valid[w_acc_idx][w_store_way] <= 1'b1;
      r_tag  [w_acc_idx][w_store_way] <= w_acc_tag;
      r_data [w_acc_idx][w_store_way] <= w_store_data;
    end else if (w_fill) begin
      r_valid[w_acc_idx][w_victim_sel] <= 1'b1;
      r_tag  [w_acc_idx][w_victim_sel] <= w_acc_tag;
      r_data [w_acc_idx][w_victim_sel] <= mem_rdata_i;
    end
  end

  // Memory-side registers double as the latched request copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      r_wr_hit    <= 1'b0;
    end else if (w_mem_start) begin
      mem_req_o   <= 1'b1;
      mem_we_o    <= cpu_we_i;
      mem_addr_o  <= cpu_addr_i & c_off_mask;
      mem_wdata_o <= cpu_we_i ? cpu_wdata_i : '0;
      mem_be_o    <= cpu_we_i ? cpu_be_i : '1;
      r_wr_hit    <= w_hit;
    end else if ((r_state != IDLE) && mem_ack_i) begin
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_stat_hits;
  logic [31:0] r_stat_misses;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_hits   <= '0;
      r_stat_misses <= '0;
    end else if (ready_o) begin
      if (hit_o && !(&r_stat_hits))     r_stat_hits   <= r_stat_hits + 32'd1;
      if (!hit_o && !(&r_stat_misses))  r_stat_misses <= r_stat_misses + 32'd1;
    end
  end

  assign stat_hits_o   = r_stat_hits;
  assign stat_misses_o = r_stat_misses;
`endif

endmodule

`default_nettype wire
